// File: rtl/axis_elastic_pipeline_if.sv
// AXI-Stream beat bundle used on both sides of the elastic pipeline.
interface axis_elastic_pipeline_if #(
    parameter int DATA_BITS = 24,
    parameter int USER_BITS = 1
);
    logic [DATA_BITS-1:0] data;
    logic [USER_BITS-1:0] user;
    logic                 last;
    logic                 valid;
    logic                 ready;

    modport master (output data, user, last, valid, input ready);
    modport slave  (input data, user, last, valid, output ready);
endinterface

// File: rtl/axis_elastic_pipeline.sv
// Elastic AXI-Stream register pipeline: backpressure-safe stages, optional
// skid-buffered (registered-ready) stages, and a registered occupancy count.
module axis_elastic_pipeline #(
    parameter int DATA_BITS        = 24,
    parameter int USER_BITS        = 1,
    parameter int PIPELINE_STAGES  = 2,
    parameter int REGISTERED_READY = 0,
    parameter int OCC_BITS         = $clog2(2*PIPELINE_STAGES+1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    axis_elastic_pipeline_if.slave  axis_s,
    axis_elastic_pipeline_if.master axis_m,
    output logic [OCC_BITS-1:0]     occupancy_o
);
    localparam int N         = PIPELINE_STAGES;
    localparam int BEAT_BITS = DATA_BITS + USER_BITS + 1;

    // link k is the input side of stage k; link N is the output port
    logic [BEAT_BITS-1:0] link_beat  [N+1];
    logic                 link_valid [N+1];
    logic                 link_ready [N+1];

    assign link_beat[0]  = {axis_s.data, axis_s.user, axis_s.last};
    assign link_valid[0] = axis_s.valid;
    assign axis_s.ready  = link_ready[0];

    assign {axis_m.data, axis_m.user, axis_m.last} = link_beat[N];
    assign axis_m.valid  = link_valid[N];
    assign link_ready[N] = axis_m.ready;

    generate
        if (REGISTERED_READY == 0) begin : g_comb
            logic [N-1:0] stage_valid;
            logic [N-1:0] ready_vec;

            // Ready ripples back from the sink; an empty stage is always ready.
            always_comb begin
                logic r;
                ready_vec = '0;
                r = link_ready[N];
                for (int k = N - 1; k >= 0; k--) begin
                    r = !stage_valid[k] || r;
                    ready_vec[k] = r;
                end
            end

            for (genvar gi = 0; gi < N; gi++) begin : g_stage
                logic                 valid_reg;
                logic [BEAT_BITS-1:0] beat_reg;

                assign stage_valid[gi]  = valid_reg;
                assign link_ready[gi]   = ready_vec[gi];
                assign link_valid[gi+1] = valid_reg;
                assign link_beat[gi+1]  = beat_reg;

                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        valid_reg <= 1'b0;
                    end else if (ready_vec[gi]) begin
                        valid_reg <= link_valid[gi];
                    end
                    if (ready_vec[gi] && link_valid[gi]) begin
                        beat_reg <= link_beat[gi];
                    end
                end
            end
        end else begin : g_skid
            for (genvar gi = 0; gi < N; gi++) begin : g_stage
                logic                 main_valid_reg;
                logic                 skid_valid_reg;
                logic                 ready_reg;
                logic [BEAT_BITS-1:0] main_beat_reg;
                logic [BEAT_BITS-1:0] skid_beat_reg;
                logic                 stage_accept;
                logic                 stage_out_fire;

                assign stage_accept     = link_valid[gi] && ready_reg;
                assign stage_out_fire   = main_valid_reg && link_ready[gi+1];
                assign link_ready[gi]   = ready_reg;
                assign link_valid[gi+1] = main_valid_reg;
                assign link_beat[gi+1]  = main_beat_reg;

                // ready_reg tracks !skid_valid, but is forced low while in reset
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        main_valid_reg <= 1'b0;
                        skid_valid_reg <= 1'b0;
                        ready_reg      <= 1'b0;
                    end else if (skid_valid_reg) begin
                        if (stage_out_fire) begin
                            main_beat_reg  <= skid_beat_reg;
                            skid_valid_reg <= 1'b0;
                            ready_reg      <= 1'b1;
                        end
                    end else if (stage_accept) begin
                        if (!main_valid_reg || stage_out_fire) begin
                            main_valid_reg <= 1'b1;
                            main_beat_reg  <= link_beat[gi];
                        end else begin
                            skid_valid_reg <= 1'b1;
                            skid_beat_reg  <= link_beat[gi];
                            ready_reg      <= 1'b0;
                        end
                    end else begin
                        if (stage_out_fire) begin
                            main_valid_reg <= 1'b0;
                        end
                        ready_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    logic                pipe_in_fire;
    logic                pipe_out_fire;
    logic [OCC_BITS-1:0] occ_reg;

    assign pipe_in_fire  = axis_s.valid && link_ready[0];
    assign pipe_out_fire = link_valid[N] && link_ready[N];
    assign occupancy_o   = occ_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_reg <= '0;
        end else if (pipe_in_fire && !pipe_out_fire) begin
            occ_reg <= occ_reg + OCC_BITS'(1);
        end else if (pipe_out_fire && !pipe_in_fire) begin
            occ_reg <= occ_reg - OCC_BITS'(1);
        end
    end
endmodule
